// File: rtl/sbox_layer_dec_if.sv
// Block handshake between the inverse permutation stage, the inverse
// S-box layer and the round-key addition downstream.
interface sbox_layer_dec_if;
    logic [63:0] state;
    logic        enable_in;
    logic [63:0] out;
    logic        enable_out;
    logic        busy;

    modport master (
        output state,
        output enable_in,
        input  out,
        input  enable_out,
        input  busy
    );

    modport slave (
        input  state,
        input  enable_in,
        output out,
        output enable_out,
        output busy
    );
endinterface

// File: rtl/sbox_layer_dec.sv
// PRESENT inverse S-box layer: substitutes NIBBLES_PER_CYCLE nibbles per
// clock, least-significant group first, and strobes the finished block.
module sbox_layer_dec #(
    parameter int NIBBLES_PER_CYCLE = 4
) (
    input  logic             clock,
    input  logic             reset,
    sbox_layer_dec_if.slave  bus
);

    localparam int N  = NIBBLES_PER_CYCLE;
    localparam int P  = 16 / N;
    localparam int CW = (P > 1) ? $clog2(P) : 1;

    if (!(N == 1 || N == 2 || N == 4 || N == 8 || N == 16)) begin : g_bad_n
        $error("NIBBLES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic {
        IDLE,
        BUSY
    } fsm_t;

    fsm_t          fsm_q, fsm_n;
    logic [63:0]   work_q, work_n;
    logic [63:0]   out_q, out_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          eo_q, eo_n;
    logic [63:0]   sub;

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        unique case (x)
            4'h0: y = 4'h5;
            4'h1: y = 4'hE;
            4'h2: y = 4'hF;
            4'h3: y = 4'h8;
            4'h4: y = 4'hC;
            4'h5: y = 4'h1;
            4'h6: y = 4'h2;
            4'h7: y = 4'hD;
            4'h8: y = 4'hB;
            4'h9: y = 4'h4;
            4'hA: y = 4'h6;
            4'hB: y = 4'h3;
            4'hC: y = 4'h0;
            4'hD: y = 4'h7;
            4'hE: y = 4'h9;
            default: y = 4'hA;
        endcase
        return y;
    endfunction

    // Work register with only the current group replaced
    always_comb begin
        sub = work_q;
        for (int g = 0; g < P; g++) begin
            if (cnt_q == CW'(g)) begin
                for (int j = 0; j < N; j++) begin
                    sub[(g*N+j)*4 +: 4] = inv_sbox(work_q[(g*N+j)*4 +: 4]);
                end
            end
        end
    end

    always_comb begin
        fsm_n  = fsm_q;
        work_n = work_q;
        out_n  = out_q;
        cnt_n  = cnt_q;
        eo_n   = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                if (bus.enable_in) begin
                    work_n = bus.state;
                    cnt_n  = '0;
                    fsm_n  = BUSY;
                end
            end
            BUSY: begin
                work_n = sub;
                if (cnt_q == CW'(P - 1)) begin
                    out_n = sub;
                    eo_n  = 1'b1;
                    cnt_n = '0;
                    fsm_n = IDLE;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            default: fsm_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q  <= IDLE;
            work_q <= '0;
            out_q  <= '0;
            cnt_q  <= '0;
            eo_q   <= 1'b0;
        end else begin
            fsm_q  <= fsm_n;
            work_q <= work_n;
            out_q  <= out_n;
            cnt_q  <= cnt_n;
            eo_q   <= eo_n;
        end
    end

    assign bus.out        = out_q;
    assign bus.enable_out = eo_q;
    assign bus.busy       = (fsm_q == BUSY);

endmodule

// File: tb/tb_sbox_layer_dec.sv
// Directed and randomized checks of the inverse S-box layer against a
// table-lookup model, including width sweep, collisions and reset abort.
module tb_sbox_layer_dec;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    sbox_layer_dec_if m();
    sbox_layer_dec_if s1();
    sbox_layer_dec_if s2();
    sbox_layer_dec_if s8();
    sbox_layer_dec_if s16();

    logic [63:0] sw_state = '0;
    logic        sw_en = 1'b0;

    assign s1.state      = sw_state;
    assign s1.enable_in  = sw_en;
    assign s2.state      = sw_state;
    assign s2.enable_in  = sw_en;
    assign s8.state      = sw_state;
    assign s8.enable_in  = sw_en;
    assign s16.state     = sw_state;
    assign s16.enable_in = sw_en;

    sbox_layer_dec #(.NIBBLES_PER_CYCLE(4)) dut (
        .clock (clock), .reset (reset), .bus (m.slave));
    sbox_layer_dec #(.NIBBLES_PER_CYCLE(1)) dut1 (
        .clock (clock), .reset (reset), .bus (s1.slave));
    sbox_layer_dec #(.NIBBLES_PER_CYCLE(2)) dut2 (
        .clock (clock), .reset (reset), .bus (s2.slave));
    sbox_layer_dec #(.NIBBLES_PER_CYCLE(8)) dut8 (
        .clock (clock), .reset (reset), .bus (s8.slave));
    sbox_layer_dec #(.NIBBLES_PER_CYCLE(16)) dut16 (
        .clock (clock), .reset (reset), .bus (s16.slave));

    function automatic logic [63:0] ref_model(input logic [63:0] v);
        logic [3:0]  tbl [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                                  4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = tbl[v[4*i +: 4]];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One block into the N=4 instance, with an optional second pulse at
    // negedge 'coll_at' after capture (negative disables it).
    task automatic run_main(input logic [63:0] v, input int coll_at,
                            input logic [63:0] v2, output int lat,
                            output int pulses, output logic [63:0] o);
        @(negedge clock);
        m.state = v;
        m.enable_in = 1'b1;
        @(negedge clock);
        m.enable_in = 1'b0;
        m.state = {$urandom, $urandom};
        lat = -1;
        pulses = 0;
        o = '0;
        for (int k = 0; k < 24; k++) begin
            if (m.enable_out === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    o = m.out;
                end
            end
            if (k == coll_at) begin
                m.state = v2;
                m.enable_in = 1'b1;
            end else begin
                m.enable_in = 1'b0;
            end
            @(negedge clock);
        end
    endtask

    initial begin
        int          lat, pulses;
        logic [63:0] o, v;
        logic [63:0] st [40];
        logic [63:0] last;
        logic        have_last;
        int          l1, l2, l8, l16;
        logic [63:0] o1, o2, o8, o16;
        logic [63:0] vecs_in [3]  = '{64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0123456789ABCDEF};
        logic [63:0] vecs_out [3] = '{64'h5555555555555555, 64'hAAAAAAAAAAAAAAAA,
                                      64'h5EF8C12DB463079A};

        m.state = {$urandom, $urandom};
        m.enable_in = 1'b1;

        // Reset held with enable_in high
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("rst_out", m.out, 64'h0);
            chk("rst_eo", {63'h0, m.enable_out}, 64'h0);
            chk("rst_busy", {63'h0, m.busy}, 64'h0);
        end
        reset = 1'b0;
        m.enable_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("post_rst_busy", {63'h0, m.busy}, 64'h0);
            chk("post_rst_eo", {63'h0, m.enable_out}, 64'h0);
        end

        // Known vectors, model cross-check and random blocks
        for (int i = 0; i < 3; i++) begin
            chk("vec_model", ref_model(vecs_in[i]), vecs_out[i]);
            run_main(vecs_in[i], -1, '0, lat, pulses, o);
            chk("vec_lat", 64'(lat), 64'd4);
            chk("vec_pulses", 64'(pulses), 64'd1);
            chk("vec_out", o, vecs_out[i]);
            chk("vec_hold", m.out, vecs_out[i]);
        end
        for (int i = 0; i < 6; i++) begin
            v = {$urandom, $urandom};
            run_main(v, -1, '0, lat, pulses, o);
            chk("rnd_lat", 64'(lat), 64'd4);
            chk("rnd_out", o, ref_model(v));
        end

        // Width sweep
        @(negedge clock);
        sw_state = 64'h0123456789ABCDEF;
        sw_en = 1'b1;
        @(negedge clock);
        sw_en = 1'b0;
        l1 = -1; l2 = -1; l8 = -1; l16 = -1;
        o1 = '0; o2 = '0; o8 = '0; o16 = '0;
        for (int k = 0; k < 24; k++) begin
            if (s1.enable_out === 1'b1 && l1 < 0) begin l1 = k; o1 = s1.out; end
            if (s2.enable_out === 1'b1 && l2 < 0) begin l2 = k; o2 = s2.out; end
            if (s8.enable_out === 1'b1 && l8 < 0) begin l8 = k; o8 = s8.out; end
            if (s16.enable_out === 1'b1 && l16 < 0) begin l16 = k; o16 = s16.out; end
            @(negedge clock);
        end
        chk("n1_lat", 64'(l1), 64'd16);
        chk("n2_lat", 64'(l2), 64'd8);
        chk("n8_lat", 64'(l8), 64'd2);
        chk("n16_lat", 64'(l16), 64'd1);
        chk("n1_out", o1, 64'h5EF8C12DB463079A);
        chk("n2_out", o2, 64'h5EF8C12DB463079A);
        chk("n8_out", o8, 64'h5EF8C12DB463079A);
        chk("n16_out", o16, 64'h5EF8C12DB463079A);

        // Collisions: mid-block and on the final busy cycle
        run_main(64'h0, 1, 64'hFFFFFFFFFFFFFFFF, lat, pulses, o);
        chk("coll_lat", 64'(lat), 64'd4);
        chk("coll_pulses", 64'(pulses), 64'd1);
        chk("coll_out", o, 64'h5555555555555555);
        run_main(64'hFFFFFFFFFFFFFFFF, 3, 64'h0, lat, pulses, o);
        chk("coll_last_pulses", 64'(pulses), 64'd1);
        chk("coll_last_out", o, 64'hAAAAAAAAAAAAAAAA);
        chk("coll_last_hold", m.out, 64'hAAAAAAAAAAAAAAAA);

        // Back-to-back with enable_in held high
        have_last = 1'b0;
        last = '0;
        for (int j = 0; j < 35; j++) begin
            st[j] = {$urandom, $urandom};
            m.state = st[j];
            m.enable_in = 1'b1;
            @(negedge clock);
            chk("b2b_eo", {63'h0, m.enable_out}, {63'h0, (j % 5) == 4});
            chk("b2b_busy", {63'h0, m.busy}, {63'h0, (j % 5) != 4});
            if ((j % 5) == 4) begin
                last = ref_model(st[j-4]);
                have_last = 1'b1;
            end
            if (have_last) chk("b2b_out", m.out, last);
        end
        m.enable_in = 1'b0;
        repeat (6) @(negedge clock);

        // Reset in the middle of a block
        m.state = 64'h0123456789ABCDEF;
        m.enable_in = 1'b1;
        @(negedge clock);
        m.enable_in = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("mid_rst_out", m.out, 64'h0);
        chk("mid_rst_busy", {63'h0, m.busy}, 64'h0);
        @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (m.enable_out === 1'b1) pulses++;
        end
        chk("mid_rst_pulses", 64'(pulses), 64'd0);
        chk("mid_rst_out_after", m.out, 64'h0);
        run_main(64'h0123456789ABCDEF, -1, '0, lat, pulses, o);
        chk("fresh_lat", 64'(lat), 64'd4);
        chk("fresh_out", o, 64'h5EF8C12DB463079A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
